// File: rtl/reset_sequencer_if.sv
// Reset request/response bundle between request sources and the reset sequencer.
// The master side raises requests and observes the sequenced resets; the sequencer is the slave.
interface reset_sequencer_if #(
  parameter int NREQ = 2,
  parameter int NOUT = 3
);
  logic [NREQ-1:0] ResetReq;
  logic            SwReq;
  logic            CauseClear;
  logic [NOUT-1:0] ResetOut;
  logic            ResetDone;
  logic [NREQ:0]   ResetCause;

  modport master (
    output ResetReq, SwReq, CauseClear,
    input  ResetOut, ResetDone, ResetCause
  );

  modport slave (
    input  ResetReq, SwReq, CauseClear,
    output ResetOut, ResetDone, ResetCause
  );
endinterface

// File: rtl/reset_sequencer.sv
// Ordered reset release: synchronises async requests, holds all outputs for a minimum time,
// then deasserts ResetOut[0..NOUT-1] one by one with a fixed gap and records the reset cause.
module reset_sequencer #(
  parameter int NREQ       = 2,
  parameter int NOUT       = 3,
  parameter int SYNCSTAGES = 2,
  parameter int HOLDCYCLES = 16,
  parameter int STAGEGAP   = 4
) (
  input  logic             clk,
  input  logic             reset,
  reset_sequencer_if.slave bus
);

  localparam int MAXC = (HOLDCYCLES > STAGEGAP) ? HOLDCYCLES : STAGEGAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int SW   = $clog2(NOUT + 1);

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   cnt_next;
  logic [SW-1:0]   stage_reg;
  logic [NOUT-1:0] out_reg;
  logic [NOUT-1:0] rel_mask;
  logic            done_reg;
  logic [NREQ:0]   cause_reg;
  logic [NREQ:0]   cause_next;
  logic [NREQ-1:0] req_sync;
  logic            req;

  genvar gi;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_sync
      logic [SYNCSTAGES-1:0] sync_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNCSTAGES-2:0], bus.ResetReq[gi]};
        end
      end
      assign req_sync[gi] = sync_reg[SYNCSTAGES-1];
    end

    // One-hot mask of the output released by the current stage index.
    for (gi = 0; gi < NOUT; gi++) begin : g_mask
      assign rel_mask[gi] = (stage_reg == SW'(gi));
    end
  endgenerate

  assign req        = (|req_sync) | bus.SwReq;
  assign cnt_next   = cnt_reg + CW'(1);
  assign cause_next = (bus.CauseClear ? '0 : cause_reg) | {bus.SwReq, req_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_ASSERT;
      cnt_reg   <= '0;
      stage_reg <= '0;
      out_reg   <= '1;
      done_reg  <= 1'b0;
    end else if (req) begin
      state_reg <= ST_ASSERT;
      cnt_reg   <= '0;
      stage_reg <= '0;
      out_reg   <= '1;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          if (cnt_next == CW'(HOLDCYCLES)) begin
            state_reg <= ST_RELEASE;
            cnt_reg   <= '0;
            stage_reg <= SW'(1);
            out_reg   <= out_reg & ~NOUT'(1);
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        ST_RELEASE: begin
          if (cnt_next == CW'(STAGEGAP)) begin
            cnt_reg <= '0;
            // Reaching the stage count consumes one final gap before RUN.
            if (stage_reg == SW'(NOUT)) begin
              state_reg <= ST_RUN;
              done_reg  <= 1'b1;
            end else begin
              out_reg   <= out_reg & ~rel_mask;
              stage_reg <= stage_reg + SW'(1);
            end
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cause_reg <= '0;
    end else begin
      cause_reg <= cause_next;
    end
  end

  assign bus.ResetOut   = out_reg;
  assign bus.ResetDone  = done_reg;
  assign bus.ResetCause = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default config (a) and NOUT=1/HOLD=1/GAP=1 config (b) share request inputs.
// A cycle-level model of the release timeline is checked every cycle, plus literal expectations.
module tb_reset_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_a;
  logic       reset_b;
  logic [1:0] req_raw;
  logic       sw;
  logic       clr;

  int n_checks = 0;
  int n_fail   = 0;

  reset_sequencer_if #(.NREQ(2), .NOUT(3)) ifa ();
  reset_sequencer_if #(.NREQ(2), .NOUT(1)) ifb ();

  assign ifa.ResetReq   = req_raw;
  assign ifa.SwReq      = sw;
  assign ifa.CauseClear = clr;
  assign ifb.ResetReq   = req_raw;
  assign ifb.SwReq      = sw;
  assign ifb.CauseClear = clr;

  reset_sequencer #(
    .NREQ(2), .NOUT(3), .SYNCSTAGES(SYNC), .HOLDCYCLES(16), .STAGEGAP(4)
  ) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (ifa)
  );

  reset_sequencer #(
    .NREQ(2), .NOUT(1), .SYNCSTAGES(SYNC), .HOLDCYCLES(1), .STAGEGAP(1)
  ) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
    $display("txn %-22s got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: k counts consecutive request-free edges since the last reset or request.
  // Output i is released once k reaches HOLD + i*GAP; done once k reaches HOLD + NOUT*GAP.
  int         k_m     [2];
  logic [2:0] cause_m [2];
  logic [1:0] hist_m  [2][SYNC];
  bit         model_started = 1'b0;

  function automatic logic [2:0] exp_out(input int k, input int hold, input int gap, input int nout);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < nout; i++) r[i] = (k < hold + i * gap);
    return r;
  endfunction

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      logic       rst;
      logic [1:0] synced;
      logic       reqv;
      rst = (n == 0) ? reset_a : reset_b;
      if (rst) begin
        k_m[n]     = 0;
        cause_m[n] = 3'b000;
        for (int s = 0; s < SYNC; s++) hist_m[n][s] = 2'b00;
      end else begin
        // Value sampled SYNC edges ago is what the synchroniser presents now.
        synced = hist_m[n][0];
        for (int s = 0; s < SYNC - 1; s++) hist_m[n][s] = hist_m[n][s+1];
        hist_m[n][SYNC-1] = req_raw;
        reqv = (|synced) | sw;
        if (reqv) k_m[n] = 0;
        else if (k_m[n] < 100000) k_m[n] = k_m[n] + 1;
        cause_m[n] = (clr ? 3'b000 : cause_m[n]) | {sw, synced};
      end
    end
    model_started = 1'b1;
  end

  always @(negedge clk) begin
    if (model_started) begin
      check("model_out_a",   {29'd0, ifa.ResetOut},   {29'd0, exp_out(k_m[0], 16, 4, 3)});
      check("model_done_a",  {31'd0, ifa.ResetDone},  {31'd0, k_m[0] >= 16 + 3 * 4});
      check("model_cause_a", {29'd0, ifa.ResetCause}, {29'd0, cause_m[0]});
      check("model_out_b",   {31'd0, ifb.ResetOut},   {29'd0, exp_out(k_m[1], 1, 1, 1)});
      check("model_done_b",  {31'd0, ifb.ResetDone},  {31'd0, k_m[1] >= 1 + 1 * 1});
      check("model_cause_b", {29'd0, ifb.ResetCause}, {29'd0, cause_m[1]});
    end
  end

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    req_raw = 2'b00;
    sw      = 1'b0;
    clr     = 1'b0;

    // Power-on: three reset cycles, then release both instances together.
    wait_n(3);
    lit("por_out_a_in_reset", {29'd0, ifa.ResetOut}, 32'h7);
    lit("por_done_a_in_reset", {31'd0, ifa.ResetDone}, 32'h0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    wait_n(1);  // after edge 1
    lit("small_out_e1", {31'd0, ifb.ResetOut}, 32'h0);
    lit("small_done_e1", {31'd0, ifb.ResetDone}, 32'h0);
    wait_n(1);  // after edge 2
    lit("small_done_e2", {31'd0, ifb.ResetDone}, 32'h1);
    wait_n(13); // after edge 15
    lit("por_out_e15", {29'd0, ifa.ResetOut}, 32'h7);
    wait_n(1);
    lit("por_out_e16", {29'd0, ifa.ResetOut}, 32'h6);
    wait_n(3);
    lit("por_out_e19", {29'd0, ifa.ResetOut}, 32'h6);
    wait_n(1);
    lit("por_out_e20", {29'd0, ifa.ResetOut}, 32'h4);
    wait_n(4);
    lit("por_out_e24", {29'd0, ifa.ResetOut}, 32'h0);
    lit("por_done_e24", {31'd0, ifa.ResetDone}, 32'h0);
    wait_n(4);
    lit("por_done_e28", {31'd0, ifa.ResetDone}, 32'h1);
    lit("por_cause_e28", {29'd0, ifa.ResetCause}, 32'h0);

    // Async request in RUN: ResetReq[1] sampled high at edges e..e+4.
    req_raw = 2'b10;
    wait_n(2);  // after e+1
    lit("async_out_e1", {29'd0, ifa.ResetOut}, 32'h0);
    wait_n(1);  // after e+2
    lit("async_out_e2", {29'd0, ifa.ResetOut}, 32'h7);
    lit("async_cause_e2", {29'd0, ifa.ResetCause}, 32'h2);
    wait_n(2);  // after e+4
    req_raw = 2'b00;
    wait_n(17); // after e+21
    lit("async_out_e21", {29'd0, ifa.ResetOut}, 32'h7);
    wait_n(1);
    lit("async_out_e22", {29'd0, ifa.ResetOut}, 32'h6);
    wait_n(12); // after e+34
    lit("async_done_e34", {31'd0, ifa.ResetDone}, 32'h1);

    // Cause precedence: clear and SwReq on the same edge s.
    clr = 1'b1;
    sw  = 1'b1;
    wait_n(1);
    clr = 1'b0;
    sw  = 1'b0;
    lit("prec_cause", {29'd0, ifa.ResetCause}, 32'h4);
    lit("prec_out", {29'd0, ifa.ResetOut}, 32'h7);
    wait_n(16); // after s+16
    lit("swrel_out_s16", {29'd0, ifa.ResetOut}, 32'h6);

    // SwReq one cycle into RELEASE re-asserts everything.
    sw = 1'b1;
    wait_n(1);  // after s+17
    sw = 1'b0;
    lit("swrel_out_s17", {29'd0, ifa.ResetOut}, 32'h7);
    lit("swrel_cause_s17", {29'd0, ifa.ResetCause}, 32'h4);
    wait_n(15);
    lit("swrel_out_s32", {29'd0, ifa.ResetOut}, 32'h7);
    wait_n(1);
    lit("swrel_out_s33", {29'd0, ifa.ResetOut}, 32'h6);
    wait_n(12);
    lit("swrel_done_s45", {31'd0, ifa.ResetDone}, 32'h1);

    clr = 1'b1;
    wait_n(1);
    clr = 1'b0;
    lit("clear_cause", {29'd0, ifa.ResetCause}, 32'h0);

    // Port reset during ASSERT with the hold counter at 10; small config reset from RUN.
    sw = 1'b1;
    wait_n(1);
    sw = 1'b0;
    wait_n(10);
    lit("mid_out_cnt10", {29'd0, ifa.ResetOut}, 32'h7);
    lit("mid_cause_cnt10", {29'd0, ifa.ResetCause}, 32'h4);
    reset_a = 1'b1;
    reset_b = 1'b1;
    wait_n(1);
    lit("mid_cause_reset", {29'd0, ifa.ResetCause}, 32'h0);
    lit("small_out_reset", {31'd0, ifb.ResetOut}, 32'h1);
    reset_a = 1'b0;
    reset_b = 1'b0;
    wait_n(1);
    lit("small_out_r1", {31'd0, ifb.ResetOut}, 32'h0);
    wait_n(1);
    lit("small_done_r2", {31'd0, ifb.ResetDone}, 32'h1);
    wait_n(13);
    lit("mid_out_r15", {29'd0, ifa.ResetOut}, 32'h7);
    wait_n(1);
    lit("mid_out_r16", {29'd0, ifa.ResetOut}, 32'h6);
    wait_n(12);
    lit("mid_done_r28", {31'd0, ifa.ResetDone}, 32'h1);
    wait_n(2);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
